// File: rtl/scr_base_l3_bk_pkg.sv
// Shared types and constants for the L3 bank tag-pipe compare stage.
// Holds the result payload carried by the output and skid registers, and the replacement LFSR.
package scr_base_l3_bk_pkg;

    localparam int unsigned L3_LFSR_W    = 16;
    localparam logic [15:0] L3_LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 counted from the shift-out end (bits 0,2,3,5).
    localparam logic [15:0] L3_LFSR_TAPS = 16'h002D;

    // Payload field widths cover the largest supported configuration.
    localparam int unsigned L3_RES_ID_W  = 16;
    localparam int unsigned L3_RES_IDX_W = 32;
    localparam int unsigned L3_RES_WAY_W = 5;

    typedef struct packed {
        logic [L3_RES_ID_W-1:0]  id;
        logic [L3_RES_IDX_W-1:0] idx;
        logic                    hit;
        logic [L3_RES_WAY_W-1:0] hit_way;
        logic                    multihit;
        logic                    victim_vld;
        logic [L3_RES_WAY_W-1:0] victim_way;
        logic                    victim_inv;
    } l3_tp_cmp_res_t;

    function automatic logic [L3_LFSR_W-1:0] l3_lfsr_next(input logic [L3_LFSR_W-1:0] s);
        logic fb;
        fb = ^(s & L3_LFSR_TAPS);
        return {fb, s[L3_LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/scr_base_l3_bk_tp_vsel.sv
// Combinational victim selector: lowest enabled invalid way first,
// otherwise the first enabled way at or above the start point, wrapping.
module scr_base_l3_bk_tp_vsel #(
    parameter int unsigned WAYS  = 8,
    parameter int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  way_en,
    input  logic [WAYS-1:0]  way_vld,
    input  logic [WAY_W-1:0] start,
    output logic             victim_vld_c,
    output logic [WAY_W-1:0] victim_way_c,
    output logic             victim_inv_c
);

    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic             rot_found;
    logic [WAY_W-1:0] rot_way;
    logic [WAY_W-1:0] cand;

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        rot_found = 1'b0;
        rot_way   = '0;
        cand      = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && way_en[w] && !way_vld[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        // WAYS is a power of two, so the index add wraps on its own.
        for (int k = 0; k < WAYS; k++) begin
            cand = start + WAY_W'(k);
            if (!rot_found && way_en[cand]) begin
                rot_found = 1'b1;
                rot_way   = cand;
            end
        end
    end

    always_comb begin
        victim_vld_c = |way_en;
        victim_way_c = '0;
        victim_inv_c = 1'b0;
        if (inv_found) begin
            victim_way_c = inv_way;
            victim_inv_c = 1'b1;
        end else if (rot_found) begin
            victim_way_c = rot_way;
        end
    end

endmodule

// File: rtl/scr_base_l3_bk_tp_cmp.sv
// L3 bank tag-pipe compare stage: hit/way/multi-hit and victim selection,
// registered through an output register plus one-entry skid, with hit/miss counters.
module scr_base_l3_bk_tp_cmp
    import scr_base_l3_bk_pkg::*;
#(
    parameter int unsigned WAYS  = 8,
    parameter int unsigned TAG_W = 24,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned ID_W  = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     rst_n,
    input  logic                     clk,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [ID_W-1:0]          in_id,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [WAYS-1:0]          in_way_vld,
    input  logic [WAYS*TAG_W-1:0]    in_way_tag,
    input  logic [WAYS-1:0]          cfg_way_en,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [ID_W-1:0]          out_id,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_hit,
    output logic [$clog2(WAYS)-1:0]  out_hit_way,
    output logic                     out_multihit,
    output logic                     out_victim_vld,
    output logic [$clog2(WAYS)-1:0]  out_victim_way,
    output logic                     out_victim_inv,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         stat_hit_cnt,
    output logic [CNT_W-1:0]         stat_miss_cnt
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAYS-1:0]      match;
    logic                 hit_c;
    logic [WAY_W-1:0]     hit_way_c;
    logic                 multihit_c;
    logic                 found;
    logic                 vic_vld_c;
    logic [WAY_W-1:0]     vic_way_c;
    logic                 vic_inv_c;
    l3_tp_cmp_res_t       res_c;

    l3_tp_cmp_res_t       res_q, res_n;
    l3_tp_cmp_res_t       skid_q, skid_n;
    logic                 out_vld_q, out_vld_n;
    logic                 skid_full_q, skid_full_n;
    logic                 in_rdy_q;
    logic [L3_LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_n;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_n;
    logic                 accept;

    assign accept = in_vld & in_rdy_q;

    // Tag compare over all ways; the way-enable mask only restricts victims.
    always_comb begin
        match      = '0;
        hit_way_c  = '0;
        multihit_c = 1'b0;
        found      = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = in_way_vld[w] & (in_way_tag[w*TAG_W +: TAG_W] == in_tag);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) begin
                if (found) begin
                    multihit_c = 1'b1;
                end else begin
                    hit_way_c = WAY_W'(w);
                end
                found = 1'b1;
            end
        end
        hit_c = |match;
    end

    scr_base_l3_bk_tp_vsel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_vsel (
        .way_en       (cfg_way_en),
        .way_vld      (in_way_vld),
        .start        (lfsr_q[WAY_W-1:0]),
        .victim_vld_c (vic_vld_c),
        .victim_way_c (vic_way_c),
        .victim_inv_c (vic_inv_c)
    );

    always_comb begin
        res_c            = '0;
        res_c.id         = L3_RES_ID_W'(in_id);
        res_c.idx        = L3_RES_IDX_W'(in_idx);
        res_c.hit        = hit_c;
        res_c.hit_way    = L3_RES_WAY_W'(hit_way_c);
        res_c.multihit   = multihit_c;
        res_c.victim_vld = vic_vld_c;
        res_c.victim_way = L3_RES_WAY_W'(vic_way_c);
        res_c.victim_inv = vic_inv_c;
    end

    // Output/skid next state: skid only fills while the output is stalled.
    always_comb begin
        res_n       = res_q;
        skid_n      = skid_q;
        out_vld_n   = out_vld_q;
        skid_full_n = skid_full_q;
        if (out_vld_q && out_rdy) begin
            if (skid_full_q) begin
                res_n       = skid_q;
                skid_full_n = 1'b0;
            end else if (accept) begin
                res_n = res_c;
            end else begin
                out_vld_n = 1'b0;
            end
        end else if (!out_vld_q) begin
            if (accept) begin
                res_n     = res_c;
                out_vld_n = 1'b1;
            end
        end else if (accept) begin
            skid_n      = res_c;
            skid_full_n = 1'b1;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_comb begin
        hit_cnt_n  = hit_cnt_q;
        miss_cnt_n = miss_cnt_q;
        if (stat_clr) begin
            hit_cnt_n  = '0;
            miss_cnt_n = '0;
        end else if (accept) begin
            if (hit_c) begin
                if (hit_cnt_q != '1) hit_cnt_n = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_n = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_full_q <= 1'b0;
            in_rdy_q    <= 1'b1;
            lfsr_q      <= L3_LFSR_SEED;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            res_q       <= res_n;
            skid_q      <= skid_n;
            out_vld_q   <= out_vld_n;
            skid_full_q <= skid_full_n;
            in_rdy_q    <= !skid_full_n;
            if (accept) lfsr_q <= l3_lfsr_next(lfsr_q);
            hit_cnt_q   <= hit_cnt_n;
            miss_cnt_q  <= miss_cnt_n;
        end
    end

    assign in_rdy         = in_rdy_q;
    assign out_vld        = out_vld_q;
    assign out_id         = res_q.id[ID_W-1:0];
    assign out_idx        = res_q.idx[IDX_W-1:0];
    assign out_hit        = res_q.hit;
    assign out_hit_way    = res_q.hit_way[WAY_W-1:0];
    assign out_multihit   = res_q.multihit;
    assign out_victim_vld = res_q.victim_vld;
    assign out_victim_way = res_q.victim_way[WAY_W-1:0];
    assign out_victim_inv = res_q.victim_inv;
    assign stat_hit_cnt   = hit_cnt_q;
    assign stat_miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_scr_base_l3_bk_tp_cmp.sv
// Bench for scr_base_l3_bk_tp_cmp: directed cases plus randomized traffic
// scored against a behavioural model (queue of expected results, LFSR, counters).
module tb_scr_base_l3_bk_tp_cmp;

    localparam int CNT_MAX = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [5:0]   in_id = '0;
    logic [9:0]   in_idx = '0;
    logic [23:0]  in_tag = '0;
    logic [7:0]   in_way_vld = '0;
    logic [191:0] in_way_tag = '0;
    logic [7:0]   cfg_way_en = '0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [5:0]   out_id;
    logic [9:0]   out_idx;
    logic         out_hit;
    logic [2:0]   out_hit_way;
    logic         out_multihit;
    logic         out_victim_vld;
    logic [2:0]   out_victim_way;
    logic         out_victim_inv;
    logic         stat_clr = 1'b0;
    logic [3:0]   stat_hit_cnt;
    logic [3:0]   stat_miss_cnt;

    scr_base_l3_bk_tp_cmp #(
        .WAYS(8), .TAG_W(24), .IDX_W(10), .ID_W(6), .CNT_W(4)
    ) dut (
        .rst_n(rst_n), .clk(clk),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id), .in_idx(in_idx),
        .in_tag(in_tag), .in_way_vld(in_way_vld), .in_way_tag(in_way_tag),
        .cfg_way_en(cfg_way_en),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_idx(out_idx),
        .out_hit(out_hit), .out_hit_way(out_hit_way), .out_multihit(out_multihit),
        .out_victim_vld(out_victim_vld), .out_victim_way(out_victim_way),
        .out_victim_inv(out_victim_inv),
        .stat_clr(stat_clr), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id; int idx; int hit; int hw; int multi; int vv; int vw; int vi;
    } exp_t;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        exp_q[$];
    int          delivered[$];
    logic [15:0] m_lfsr;
    int          m_hit;
    int          m_miss;
    bit          mon_en = 1'b0;
    logic [23:0] pool[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected result straight from the compare/victim rules.
    function automatic exp_t model(input logic [5:0] id, input logic [9:0] idx,
                                   input logic [23:0] tag, input logic [7:0] vld,
                                   input logic [191:0] tags, input logic [7:0] en,
                                   input logic [15:0] lf);
        exp_t r;
        int n;
        int c;
        r.id = int'(id); r.idx = int'(idx);
        n = 0; r.hw = 0;
        for (int w = 0; w < 8; w++) begin
            if (vld[w] && tags[w*24 +: 24] == tag) begin
                if (n == 0) r.hw = w;
                n++;
            end
        end
        r.hit = (n > 0) ? 1 : 0;
        r.multi = (n > 1) ? 1 : 0;
        r.vv = (en != 0) ? 1 : 0;
        r.vw = 0; r.vi = 0;
        if (en != 0) begin
            c = -1;
            for (int w = 7; w >= 0; w--) if (en[w] && !vld[w]) c = w;
            if (c >= 0) begin
                r.vw = c; r.vi = 1;
            end else begin
                c = int'(lf) % 8;
                for (int k = 7; k >= 0; k--) if (en[(c + k) % 8]) r.vw = (c + k) % 8;
            end
        end
        return r;
    endfunction

    // Scoreboard: retire outputs, check counters, then record this cycle's acceptance.
    always @(negedge clk) begin
        exp_t e;
        logic fb;
        if (mon_en) begin
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_vld, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", out_id, e.id);
                    chk("out_idx", out_idx, e.idx);
                    chk("out_hit", out_hit, e.hit);
                    chk("out_hit_way", out_hit_way, e.hw);
                    chk("out_multihit", out_multihit, e.multi);
                    chk("victim_vld", out_victim_vld, e.vv);
                    chk("victim_way", out_victim_way, e.vw);
                    chk("victim_inv", out_victim_inv, e.vi);
                    delivered.push_back(int'(out_id));
                end
            end
            chk("hit_cnt", stat_hit_cnt, m_hit);
            chk("miss_cnt", stat_miss_cnt, m_miss);
            if (in_vld && in_rdy) begin
                e = model(in_id, in_idx, in_tag, in_way_vld, in_way_tag, cfg_way_en, m_lfsr);
                exp_q.push_back(e);
                fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = {fb, m_lfsr[15:1]};
                if (e.hit != 0) begin
                    if (m_hit < CNT_MAX) m_hit++;
                end else begin
                    if (m_miss < CNT_MAX) m_miss++;
                end
            end
            if (stat_clr) begin
                m_hit = 0; m_miss = 0;
            end
        end
    end

    function automatic logic [191:0] base_tags();
        logic [191:0] t;
        for (int w = 0; w < 8; w++) t[w*24 +: 24] = 24'h100000 + 24'(w);
        return t;
    endfunction

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic send_req(input logic [5:0] id, input logic [23:0] tag,
                            input logic [7:0] vld, input logic [191:0] tags);
        bit ok;
        in_id = id; in_idx = {4'b0, id} + 10'd100; in_tag = tag;
        in_way_vld = vld; in_way_tag = tags; in_vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", in_rdy, 1'b1);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    initial begin
        logic [191:0] t;
        bit           acc;
        int           k;
        int           fell_at;
        int           nacc;

        m_lfsr = 16'hACE1; m_hit = 0; m_miss = 0;
        #12;
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_out_hit", out_hit, 1'b0);
        chk("rst_victim_way", out_victim_way, 3'd0);
        chk("rst_hit_cnt", stat_hit_cnt, 4'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // First request after reset: rotate search from lfsr low bits 3'b001.
        cfg_way_en = 8'hF0;
        t = base_tags();
        send_req(6'd1, 24'hABCDEF, 8'hFF, t);
        @(negedge clk);
        chk("d1_out_vld", out_vld, 1'b1);
        chk("d1_hit", out_hit, 1'b0);
        chk("d1_victim_way", out_victim_way, 3'd4);
        chk("d1_victim_inv", out_victim_inv, 1'b0);
        @(posedge clk); #1;

        send_req(6'd2, 24'hABCDEF, 8'hBF, t);
        @(negedge clk);
        chk("d2_victim_way", out_victim_way, 3'd6);
        chk("d2_victim_inv", out_victim_inv, 1'b1);
        @(posedge clk); #1;

        t[3*24 +: 24] = 24'h123456;
        send_req(6'd3, 24'h123456, 8'h08, t);
        @(negedge clk);
        chk("d3_hit", out_hit, 1'b1);
        chk("d3_hit_way", out_hit_way, 3'd3);
        chk("d3_multihit", out_multihit, 1'b0);
        chk("d3_hit_cnt", stat_hit_cnt, 4'd1);
        @(posedge clk); #1;

        t = base_tags();
        t[2*24 +: 24] = 24'h123456;
        t[5*24 +: 24] = 24'h123456;
        send_req(6'd4, 24'h123456, 8'h24, t);
        @(negedge clk);
        chk("d4_hit_way", out_hit_way, 3'd2);
        chk("d4_multihit", out_multihit, 1'b1);
        @(posedge clk); #1;

        cfg_way_en = 8'h00;
        send_req(6'd5, 24'h123456, 8'h24, t);
        @(negedge clk);
        chk("d5_victim_vld", out_victim_vld, 1'b0);
        chk("d5_victim_way", out_victim_way, 3'd0);
        chk("d5_hit", out_hit, 1'b1);
        @(posedge clk); #1;

        // Back-to-back ids 0..9 with the output stalled for three cycles.
        for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
        cfg_way_en = 8'h5A;
        out_rdy = 1'b0;
        delivered.delete();
        k = 0; nacc = 0; fell_at = -1;
        for (int cyc = 0; cyc < 200 && k < 10; cyc++) begin
            in_vld = 1'b1; in_id = 6'(k); in_idx = 10'(k * 7);
            in_tag = pool[k % 4]; in_way_vld = 8'($urandom);
            for (int w = 0; w < 8; w++) in_way_tag[w*24 +: 24] = pool[$urandom_range(0, 3)];
            @(negedge clk);
            acc = in_rdy;
            if (!in_rdy && fell_at < 0) fell_at = nacc;
            @(posedge clk); #1;
            if (acc) begin nacc++; k++; end
            if (cyc == 2) out_rdy = 1'b1;
        end
        in_vld = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_in_rdy_fell_after", 64'(fell_at), 64'd2);
        chk("bp_delivered_cnt", 64'(delivered.size()), 64'd10);
        for (int i = 0; i < delivered.size(); i++) chk("bp_order", 64'(delivered[i]), 64'(i));

        // Randomized traffic with random backpressure and occasional clears.
        acc = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_vld || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_vld = 1'b1; in_id = 6'($urandom); in_idx = 10'($urandom);
                    in_tag = pool[$urandom_range(0, 3)];
                    in_way_vld = 8'($urandom);
                    for (int w = 0; w < 8; w++) in_way_tag[w*24 +: 24] = pool[$urandom_range(0, 3)];
                    cfg_way_en = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                end else begin
                    in_vld = 1'b0;
                end
            end
            out_rdy = ($urandom_range(0, 2) != 0);
            stat_clr = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            acc = in_vld && in_rdy;
            @(posedge clk); #1;
        end
        in_vld = 1'b0; stat_clr = 1'b0; out_rdy = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Counter saturation at CNT_W=4, then clear colliding with a miss.
        cfg_way_en = 8'h0F;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        for (int i = 0; i < 20; i++) send_req(6'(i), 24'h777777, 8'h00, base_tags());
        @(negedge clk);
        chk("sat_miss_cnt", stat_miss_cnt, 4'd15);
        @(posedge clk); #1;
        stat_clr = 1'b1;
        send_req(6'd21, 24'h777777, 8'h00, base_tags());
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_vs_miss", stat_miss_cnt, 4'd0);
        @(posedge clk); #1;

        // Reset in the middle of a stall drops both held entries at once.
        mon_en = 1'b0;
        out_rdy = 1'b0;
        send_req(6'd30, 24'h1, 8'h00, base_tags());
        send_req(6'd31, 24'h2, 8'h00, base_tags());
        @(negedge clk);
        chk("stall_in_rdy_low", in_rdy, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", out_vld, 1'b0);
        chk("midrst_in_rdy", in_rdy, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scr_base_l3_bk_tp_cmp.md
# scr_base_l3_bk_tp_cmp

Parametrised L3 bank tag-pipe compare stage, successor to the fixed D1 stage. It takes the set index, request tag and per-way tag/valid read data from the tag RAM output. It produces a registered hit/way/multi-hit result and a replacement victim under a programmable way-enable mask. Valid/ready flow control uses a one-entry skid buffer, giving full throughput under backpressure. Hit/miss statistics counters are included.

## Interface
- WAYS, 8, associativity; power of two, 2..32
- TAG_W, 24, tag width in bits
- IDX_W, 10, set index width
- ID_W, 6, request id width
- CNT_W, 16, statistics counter width
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  clock; all state on rising edge
- in_vld / in_rdy  in/out  1  request handshake
- in_id  in  ID_W  request id
- in_idx  in  IDX_W  set index
- in_tag  in  TAG_W  lookup tag
- in_way_vld  in  WAYS  per-way valid bits of the set
- in_way_tag  in  WAYS*TAG_W  per-way tags; way w at bits [w*TAG_W +: TAG_W]
- cfg_way_en  in  WAYS  ways allowed as victims; quasi-static
- out_vld / out_rdy  out/in  1  result handshake
- out_id, out_idx  out  ID_W, IDX_W  passed-through request fields
- out_hit  out  1  at least one valid way matched
- out_hit_way  out  $clog2(WAYS)  lowest matching way
- out_multihit  out  1  more than one valid way matched (error)
- out_victim_vld  out  1  a victim exists (cfg_way_en != 0)
- out_victim_way  out  $clog2(WAYS)  selected victim way
- out_victim_inv  out  1  victim is an invalid way
- stat_clr  in  1  synchronous clear of the counters
- stat_hit_cnt, stat_miss_cnt  out  CNT_W  saturating counters

## Operation
- Compare: match[w] = in_way_vld[w] & (in_way_tag[w] == in_tag). Hit uses all ways regardless of cfg_way_en.
- out_hit = |match. out_hit_way = lowest set bit of match, or 0 if no match. out_multihit = popcount(match) > 1.
- Victim, priority 1: the lowest-index way with cfg_way_en=1 and in_way_vld=0; out_victim_inv=1.
- Victim, priority 2: start at candidate c = lfsr[$clog2(WAYS)-1:0] and search upward with wrap for the first way with cfg_way_en=1; out_victim_inv=0.
- cfg_way_en == 0: out_victim_vld=0, out_victim_way=0, out_victim_inv=0.
- Victim is computed even on hit; the consumer ignores it.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset 16'hACE1. Advances once per accepted request (in_vld & in_rdy), after use.
- Counters: on each accepted request, increment stat_hit_cnt if out_hit, else stat_miss_cnt. Both saturate at all-ones. stat_clr zeroes both and has priority over an increment in the same cycle.

## Timing
- Result is computed combinationally from the inputs and captured in the output register on acceptance. Latency is 1 cycle: a request accepted in cycle N is presented in cycle N+1.
- The output register holds one result; the skid register holds one more. in_rdy = !skid_full and is a register output (no combinational in->out path).
- Acceptance with the output empty, or with the output draining (out_rdy=1): the result goes to the output register.
- Acceptance with the output stalled: the result goes to the skid register; in_rdy falls in the next cycle.
- When the output drains and skid is full: skid moves to the output and in_rdy rises in the next cycle.
- Outputs are stable while out_vld & !out_rdy. Ordering is strictly FIFO.
- Sustained out_rdy=1 gives one result per cycle.
- Reset values: out_vld=0, in_rdy=1, all data outputs 0, counters 0, skid empty, LFSR 16'hACE1. Reset mid-transfer discards both entries.

## Structure
- Package scr_base_l3_bk_pkg holds the LFSR seed/taps localparams and the l3_tp_cmp_res_t struct (id, idx, hit, hit_way, multihit, victim fields). The output and skid registers use this struct.
- One sub-module: scr_base_l3_bk_tp_vsel, a combinational victim selector (invalid-first, then rotate-from-start over the enable mask).

## Test plan
- WAYS=8. Way 3 valid with tag 0x123456, request tag 0x123456 -> next cycle out_hit=1, hit_way=3, multihit=0; stat_hit_cnt=1.
- Ways 2 and 5 valid with equal matching tags -> hit_way=2, multihit=1.
- All ways valid, no match, cfg_way_en=8'hF0, first request after reset (lfsr low bits 3'b001) -> victim_way=4, inv=0. Same request with way 6 invalid -> victim_way=6, inv=1.
- cfg_way_en=0 -> victim_vld=0, hit reporting unaffected.
- Back-to-back requests id 0..9 with out_rdy held low for 3 cycles -> in_rdy falls after the second acceptance; ids are delivered in order with none lost or duplicated.
- CNT_W=4: 20 misses -> stat_miss_cnt=15. stat_clr together with a miss -> count 0. Assert rst_n mid-stall -> out_vld=0 and in_rdy=1 immediately.
